// File: rtl/dcache_vec_pkg.sv
// Shared types and constants for the vector data-cache arbiter.
// Holds the FSM encoding and the cache index slice.
package dcache_vec_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_WIDTH     = 32;
    localparam int DEF_VEC_WIDTH = 64;
    localparam int INDEX_LO      = 3;
    localparam int INDEX_HI      = 9;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker, purely combinational.
// On contention the port that did not win last time is chosen.
module rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    input  logic enable,
    output logic grant0,
    output logic grant1
);

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (enable) begin
            if (valid0 && valid1) begin
                grant0 = last_grant;
                grant1 = !last_grant;
            end else begin
                grant0 = valid0;
                grant1 = valid1;
            end
        end
    end

endmodule

// File: rtl/dcache_vector_arb.sv
// Round-robin arbiter and access sequencer in front of the
// single-port vector data cache, with a stall timeout.
module dcache_vector_arb
    import dcache_vec_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int VEC_WIDTH = DEF_VEC_WIDTH,
    parameter int TIMEOUT   = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic                 req0_write,
    input  logic [WIDTH-1:0]     req0_addr,
    input  logic [VEC_WIDTH-1:0] req0_wdata,
    output logic                 resp0_valid,
    output logic                 resp0_err,
    output logic [VEC_WIDTH-1:0] resp0_rdata,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic                 req1_write,
    input  logic [WIDTH-1:0]     req1_addr,
    input  logic [VEC_WIDTH-1:0] req1_wdata,
    output logic                 resp1_valid,
    output logic                 resp1_err,
    output logic [VEC_WIDTH-1:0] resp1_rdata,
    output logic [WIDTH-1:0]     mem_address,
    output logic [VEC_WIDTH-1:0] mem_data_in,
    output logic                 mem_read,
    output logic                 mem_write,
    input  logic [VEC_WIDTH-1:0] mem_data_out,
    input  logic                 mem_valid
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] STALL_MAX = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] STALL_SAT = {CW{1'b1}};

    state_t               state;
    logic                 last_grant;
    logic                 write_l;
    logic                 id_l;
    logic [WIDTH-1:0]     addr_l;
    logic [VEC_WIDTH-1:0] wdata_l;
    logic [CW-1:0]        stall_cnt;
    logic                 accept_en;
    logic                 grant0;
    logic                 grant1;
    logic                 finish;

    assign accept_en = (state == IDLE || state == DONE) && !RST;

    rr_arb2 u_arb (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant),
        .enable     (accept_en),
        .grant0     (grant0),
        .grant1     (grant1)
    );

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Gate with RST so a store caught by reset never reaches the array.
    assign mem_address = addr_l;
    assign mem_data_in = wdata_l;
    assign mem_read    = (state == ISSUE) && !write_l && !RST;
    assign mem_write   = (state == ISSUE) && write_l && !RST;

    assign finish = mem_valid || (stall_cnt >= STALL_MAX);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            stall_cnt   <= '0;
            write_l     <= 1'b0;
            id_l        <= 1'b0;
            addr_l      <= '0;
            wdata_l     <= '0;
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            resp0_err   <= 1'b0;
            resp1_err   <= 1'b0;
            resp0_rdata <= '0;
            resp1_rdata <= '0;
        end else begin
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            resp0_err   <= 1'b0;
            resp1_err   <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (grant0 || grant1) begin
                        state      <= ISSUE;
                        id_l       <= grant1;
                        last_grant <= grant1;
                        write_l    <= grant1 ? req1_write : req0_write;
                        addr_l     <= grant1 ? req1_addr : req0_addr;
                        wdata_l    <= grant1 ? req1_wdata : req0_wdata;
                        stall_cnt  <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    if (finish) begin
                        state       <= DONE;
                        stall_cnt   <= '0;
                        resp0_valid <= !id_l;
                        resp1_valid <= id_l;
                        resp0_err   <= !id_l && !mem_valid;
                        resp1_err   <= id_l && !mem_valid;
                        // Timed-out loads keep the previous read data.
                        if (mem_valid && !write_l) begin
                            if (id_l) resp1_rdata <= mem_data_out;
                            else      resp0_rdata <= mem_data_out;
                        end
                    end else if (stall_cnt != STALL_SAT) begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
